// File: rtl/frame_swap_controller.sv
// Double-buffered 160x120 framebuffer with vblank-synchronised bank swap and 4x scanout.
// Define FRAME_SWAP_VBLANK_WAIT_EN to hold each swap until vblank_start.
module frame_swap_controller #(
  parameter int BUFFER_WIDTH      = 160,
  parameter int BUFFER_HEIGHT     = 120,
  parameter int BUFFER_DATA_WIDTH = 12,
  parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH*BUFFER_HEIGHT),
  parameter int SCALE_SHIFT       = 2,
  parameter int COORD_WIDTH       = 10
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         write_en,
  input  logic [BUFFER_ADDR_WIDTH-1:0] write_addr,
  input  logic [BUFFER_DATA_WIDTH-1:0] write_data,
  input  logic                         frame_done,
  output logic                         draw_ack,
  input  logic                         vblank_start,
  input  logic [COORD_WIDTH-1:0]       disp_x,
  input  logic [COORD_WIDTH-1:0]       disp_y,
  input  logic                         disp_active,
  output logic [BUFFER_DATA_WIDTH-1:0] rgb_out,
  output logic                         rgb_valid,
  output logic                         front_sel
);

  localparam int DEPTH = BUFFER_WIDTH * BUFFER_HEIGHT;

  typedef enum logic [2:0] {
    DRAW,
    WAIT_VBLANK,
    SWAP,
    ACK,
    HOLD
  } state_t;

  state_t state;
  logic   front_valid;

  logic [BUFFER_DATA_WIDTH-1:0] mem_a [DEPTH];
  logic [BUFFER_DATA_WIDTH-1:0] mem_b [DEPTH];

  logic wr_ok;
  assign wr_ok = write_en && (32'(write_addr) < DEPTH);

  // Bank A is the back bank while B is on screen, and vice versa.
  always_ff @(posedge clk) begin
    if (wr_ok && front_sel)
      mem_a[write_addr] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !front_sel)
      mem_b[write_addr] <= write_data;
  end

  logic [COORD_WIDTH-1:0]       sx;
  logic [COORD_WIDTH-1:0]       sy;
  logic                         in_range;
  logic [BUFFER_ADDR_WIDTH-1:0] lin_addr;

  assign sx       = disp_x >> SCALE_SHIFT;
  assign sy       = disp_y >> SCALE_SHIFT;
  assign in_range = (32'(sx) < BUFFER_WIDTH) &&
                    (32'(sy) < BUFFER_HEIGHT);
  assign lin_addr = BUFFER_ADDR_WIDTH'(
                      32'(sy) * BUFFER_WIDTH + 32'(sx));

  logic [BUFFER_ADDR_WIDTH-1:0] rd_addr;
  logic                         rd_act;
  logic                         rd_ok;
  logic                         rd_bank;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_addr <= '0;
      rd_act  <= 1'b0;
      rd_ok   <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      rd_addr <= lin_addr;
      rd_act  <= disp_active;
      rd_ok   <= in_range;
      rd_bank <= front_sel;
    end
  end

  // Bank latched with the address keeps a swap from splitting a pixel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rgb_out   <= '0;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= rd_act;
      if (rd_act && rd_ok && front_valid)
        rgb_out <= rd_bank ? mem_b[rd_addr] : mem_a[rd_addr];
      else
        rgb_out <= '0;
    end
  end

`ifndef FRAME_SWAP_VBLANK_WAIT_EN
  logic vblank_unused;
  assign vblank_unused = vblank_start;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= DRAW;
      front_sel   <= 1'b0;
      front_valid <= 1'b0;
      draw_ack    <= 1'b0;
    end else begin
      draw_ack <= 1'b0;
      unique case (state)
        DRAW: begin
          if (frame_done)
`ifdef FRAME_SWAP_VBLANK_WAIT_EN
            state <= WAIT_VBLANK;
`else
            state <= SWAP;
`endif
        end
        WAIT_VBLANK: begin
`ifdef FRAME_SWAP_VBLANK_WAIT_EN
          if (vblank_start)
            state <= SWAP;
`else
          state <= SWAP;
`endif
        end
        SWAP: begin
          front_sel   <= ~front_sel;
          front_valid <= 1'b1;
          draw_ack    <= 1'b1;
          state       <= ACK;
        end
        ACK: begin
          state <= HOLD;
        end
        // A held frame_done must drop before the next frame counts.
        HOLD: begin
          if (!frame_done)
            state <= DRAW;
        end
        default: begin
          state <= DRAW;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_swap_controller.sv
// Directed bench for frame_swap_controller: swap handshake, scanout path, reset.
// Expectations follow FRAME_SWAP_VBLANK_WAIT_EN when it is defined.
module tb_frame_swap_controller;

  logic        clk;
  logic        rstn;
  logic        write_en;
  logic [14:0] write_addr;
  logic [11:0] write_data;
  logic        frame_done;
  logic        draw_ack;
  logic        vblank_start;
  logic [9:0]  disp_x;
  logic [9:0]  disp_y;
  logic        disp_active;
  logic [11:0] rgb_out;
  logic        rgb_valid;
  logic        front_sel;

  int checks   = 0;
  int failures = 0;

  frame_swap_controller dut (
    .clk          (clk),
    .rstn         (rstn),
    .write_en     (write_en),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .frame_done   (frame_done),
    .draw_ack     (draw_ack),
    .vblank_start (vblank_start),
    .disp_x       (disp_x),
    .disp_y       (disp_y),
    .disp_active  (disp_active),
    .rgb_out      (rgb_out),
    .rgb_valid    (rgb_valid),
    .front_sel    (front_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    write_en   = 1'b1;
    write_addr = 15'(a);
    write_data = 12'(d);
    tick();
    write_en = 1'b0;
  endtask

  task automatic rd(input int x, input int y, input logic act);
    disp_x      = 10'(x);
    disp_y      = 10'(y);
    disp_active = act;
    tick();
    disp_active = 1'b0;
    tick();
  endtask

  task automatic do_swap(input string tag);
    int acks;
    int first;
    acks  = 0;
    first = -1;
    frame_done = 1'b1;
`ifdef FRAME_SWAP_VBLANK_WAIT_EN
    repeat (5) tick();
    vblank_start = 1'b1;
`endif
    for (int i = 1; i <= 8; i++) begin
      tick();
      vblank_start = 1'b0;
      if (draw_ack) begin
        acks++;
        if (first < 0) first = i;
      end
    end
    frame_done = 1'b0;
    tick();
    tick();
    check({tag, "_acks"}, acks, 1);
    check({tag, "_lat"}, first, 2);
  endtask

  initial begin
    int acks;
    int first;
    rstn         = 1'b0;
    write_en     = 1'b0;
    write_addr   = '0;
    write_data   = '0;
    frame_done   = 1'b0;
    vblank_start = 1'b0;
    disp_x       = '0;
    disp_y       = '0;
    disp_active  = 1'b0;
    repeat (3) tick();
    check("rst_ack", draw_ack, 0);
    check("rst_fsel", front_sel, 0);
    check("rst_rgb", rgb_out, 0);
    check("rst_vld", rgb_valid, 0);
    rstn = 1'b1;
    tick();

    rd(100, 100, 1'b1);
    check("nofront_rgb", rgb_out, 0);
    check("nofront_vld", rgb_valid, 1);

    wr(0, 12'hF00);
    wr(19199, 12'h0F0);
    do_swap("swap1");
    check("swap1_fsel", front_sel, 1);
    rd(0, 0, 1'b1);
    check("px_0_0", rgb_out, 12'hF00);
    check("px_0_0_vld", rgb_valid, 1);
    rd(639, 479, 1'b1);
    check("px_639_479", rgb_out, 12'h0F0);

    wr(160, 12'h555);
    wr(161, 12'hABC);
    wr(162, 12'hDEF);
    do_swap("swap2");
    check("swap2_fsel", front_sel, 0);
    for (int y = 4; y < 8; y++)
      for (int x = 4; x < 8; x++) begin
        rd(x, y, 1'b1);
        check($sformatf("up_%0d_%0d", x, y), rgb_out, 12'hABC);
      end
    rd(8, 4, 1'b1);
    check("up_8_4", rgb_out, 12'hDEF);
    rd(0, 4, 1'b1);
    check("up_0_4", rgb_out, 12'h555);
    rd(640, 0, 1'b1);
    check("oor_x_rgb", rgb_out, 0);
    check("oor_x_vld", rgb_valid, 1);
    rd(4, 4, 1'b0);
    check("inact_rgb", rgb_out, 0);
    check("inact_vld", rgb_valid, 0);

    acks = 0;
    frame_done = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      vblank_start = (i == 5 || i == 30);
      tick();
      vblank_start = 1'b0;
      if (draw_ack) acks++;
    end
    check("held_acks", acks, 1);
    check("held_fsel", front_sel, 1);
    frame_done = 1'b0;
    tick();
    tick();

    wr(0, 12'h123);
    rd(0, 0, 1'b1);
    check("back_wr_hidden", rgb_out, 12'hF00);
    do_swap("swap4");
    check("swap4_fsel", front_sel, 0);
    rd(0, 0, 1'b1);
    check("back_wr_shown", rgb_out, 12'h123);

`ifdef FRAME_SWAP_VBLANK_WAIT_EN
    acks = 0;
    frame_done = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (draw_ack) acks++;
    end
    check("novb_acks", acks, 0);
`else
    acks  = 0;
    first = -1;
    frame_done = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      frame_done = 1'b0;
      if (draw_ack) begin
        acks++;
        if (first < 0) first = i;
      end
    end
    check("bypass_acks", acks, 1);
    check("bypass_lat", first, 2);
    check("bypass_fsel", front_sel, 1);
    frame_done = 1'b1;
    tick();
`endif
    rstn = 1'b0;
    #2;
    check("mid_rst_ack", draw_ack, 0);
    check("mid_rst_fsel", front_sel, 0);
    check("mid_rst_rgb", rgb_out, 0);
    frame_done = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    rd(0, 0, 1'b1);
    check("post_rst_rgb", rgb_out, 0);
    check("post_rst_vld", rgb_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
